// File: rtl/spi_pkg.sv
// Shared opcode/state types and frame constants for the SPI master command serializer.
package spi_pkg;

    typedef enum logic [1:0] {
        WR_ADDR = 2'b00,
        WR_DATA = 2'b01,
        RD_ADDR = 2'b10,
        RD_DATA = 2'b11
    } spi_op_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_TURN,
        ST_READ,
        ST_GAP
    } spi_mstate_e;

    localparam logic SLAVE_SELECTED = 1'b0;
    localparam int   CMD_W          = 10;
    localparam int   DATA_W         = 8;

    // The slave stays selected across the command, the turnaround and the read-back.
    function automatic logic frame_active(input spi_mstate_e st);
        return (st == ST_SHIFT) || (st == ST_TURN) || (st == ST_READ);
    endfunction

endpackage

// File: rtl/spi_shift_reg.sv
// MSB-first shift register: parallel load, or shift left taking serial_in into bit 0.
module spi_shift_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] load_data,
    input  logic             serial_in,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk) begin
        // NOTE: non-blocking so every flop samples pre-edge values regardless of block order.
        if (rst) begin
            q <= '0;
        end else if (load) begin
            q <= load_data;
        end else if (shift) begin
            q <= {q[WIDTH-2:0], serial_in};
        end
    end

endmodule

// File: rtl/spi_master_cmd_serializer.sv
// Frames 10-bit RAM commands onto SS_n/MOSI and reads back a byte on MISO for RD_DATA.
// Optional SPI_MASTER_STATS_EN adds write/read frame counters.
module spi_master_cmd_serializer
    import spi_pkg::*;
#(
    parameter int TURNAROUND = 2,
    parameter int GAP_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic [7:0]  cmd_data,
    output logic        SS_n,
    output logic        MOSI,
    input  logic        MISO,
    output logic        rd_valid,
    output logic [7:0]  rd_data,
    output logic        busy
`ifdef SPI_MASTER_STATS_EN
    ,
    output logic [15:0] stat_wr_cnt,
    output logic [15:0] stat_rd_cnt
`endif
);

    spi_mstate_e       state;
    spi_mstate_e       next_state;
    logic [3:0]        cnt;
    spi_op_e           op_q;
    logic              accept;
    logic              shift_done;
    logic              read_done;
    logic [CMD_W-2:0]  tx_unused;
    logic              rx_unused;
    logic [DATA_W-2:0] rx_q;

    assign accept     = cmd_valid && cmd_ready;
    assign shift_done = (state == ST_SHIFT) && (cnt == 4'(CMD_W - 1));
    assign read_done  = (state == ST_READ) && (cnt == 4'(DATA_W - 1));

    // Zero fill keeps MOSI low once the last command bit has left.
    spi_shift_reg #(.WIDTH(CMD_W)) u_tx (
        .clk       (clk),
        .rst       (rst),
        .load      (accept),
        .shift     (state == ST_SHIFT),
        .load_data ({cmd_op, cmd_data}),
        .serial_in (1'b0),
        .q         ({MOSI, tx_unused})
    );

    // Only the first seven samples are held here; the eighth comes straight from MISO.
    spi_shift_reg #(.WIDTH(DATA_W)) u_rx (
        .clk       (clk),
        .rst       (rst),
        .load      (1'b0),
        .shift     (state == ST_READ),
        .load_data ('0),
        .serial_in (MISO),
        .q         ({rx_unused, rx_q})
    );

    always_comb begin
        // NOTE: default first so every path assigns next_state and no latch is inferred.
        next_state = state;
        case (state)
            ST_IDLE:  if (accept) next_state = ST_SHIFT;
            ST_SHIFT: if (shift_done) begin
                if (op_q != RD_DATA)      next_state = ST_GAP;
                else if (TURNAROUND == 0) next_state = ST_READ;
                else                      next_state = ST_TURN;
            end
            ST_TURN:  if (cnt == 4'(TURNAROUND - 1)) next_state = ST_READ;
            ST_READ:  if (read_done) next_state = ST_GAP;
            ST_GAP:   if (cnt == 4'(GAP_CYCLES - 1)) next_state = ST_IDLE;
            default:  next_state = ST_IDLE;
        endcase
    end

    // Outputs are registered from next_state so they line up with the state they describe.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            op_q      <= WR_ADDR;
            SS_n      <= ~SLAVE_SELECTED;
            cmd_ready <= 1'b0;
            busy      <= 1'b0;
            rd_valid  <= 1'b0;
            rd_data   <= '0;
        end else begin
            state <= next_state;
            if (next_state != state) begin
                cnt <= '0;
            end else if (state != ST_IDLE) begin
                cnt <= cnt + 4'd1;
            end
            if (accept) begin
                op_q <= spi_op_e'(cmd_op);
            end
            SS_n      <= frame_active(next_state) ? SLAVE_SELECTED : ~SLAVE_SELECTED;
            cmd_ready <= (next_state == ST_IDLE);
            busy      <= (next_state != ST_IDLE);
            rd_valid  <= read_done;
            if (read_done) begin
                rd_data <= {rx_q, MISO};
            end
        end
    end

`ifdef SPI_MASTER_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_wr_cnt <= '0;
            stat_rd_cnt <= '0;
        end else begin
            if (shift_done && (op_q != RD_DATA)) begin
                stat_wr_cnt <= stat_wr_cnt + 16'd1;
            end
            if (read_done) begin
                stat_rd_cnt <= stat_rd_cnt + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_spi_master_cmd_serializer.sv
// Scoreboard bench: expected frames/read bytes are queued at accept and compared when the DUT emits them.
module tb_spi_master_cmd_serializer;
    import spi_pkg::*;

    localparam int TA     = 2;
    localparam int GAP    = 1;
    localparam int TB_TA  = 0;
    localparam int TB_GAP = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cmd_valid = 1'b0;
    logic [1:0] cmd_op = 2'b00;
    logic [7:0] cmd_data = 8'h00;
    logic       miso = 1'b0;
    logic       ss_n, mosi, cmd_ready, rd_valid, busy;
    logic [7:0] rd_data;

    logic       cmd_valid_b = 1'b0;
    logic [1:0] cmd_op_b = 2'b00;
    logic [7:0] cmd_data_b = 8'h00;
    logic       miso_b = 1'b0;
    logic       ss_n_b, mosi_b, cmd_ready_b, rd_valid_b, busy_b;
    logic [7:0] rd_data_b;
`ifdef SPI_MASTER_STATS_EN
    logic [15:0] stat_wr_cnt, stat_rd_cnt, stat_wr_cnt_b, stat_rd_cnt_b;
`endif

    spi_master_cmd_serializer #(.TURNAROUND(TA), .GAP_CYCLES(GAP)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_data(cmd_data), .SS_n(ss_n), .MOSI(mosi), .MISO(miso),
        .rd_valid(rd_valid), .rd_data(rd_data), .busy(busy)
`ifdef SPI_MASTER_STATS_EN
        , .stat_wr_cnt(stat_wr_cnt), .stat_rd_cnt(stat_rd_cnt)
`endif
    );

    spi_master_cmd_serializer #(.TURNAROUND(TB_TA), .GAP_CYCLES(TB_GAP)) dut_b (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid_b), .cmd_ready(cmd_ready_b),
        .cmd_op(cmd_op_b), .cmd_data(cmd_data_b), .SS_n(ss_n_b), .MOSI(mosi_b), .MISO(miso_b),
        .rd_valid(rd_valid_b), .rd_data(rd_data_b), .busy(busy_b)
`ifdef SPI_MASTER_STATS_EN
        , .stat_wr_cnt(stat_wr_cnt_b), .stat_rd_cnt(stat_rd_cnt_b)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    typedef struct {
        logic [9:0] frame;
        int         low_len;
    } frame_t;

    frame_t     exp_frames[$];
    logic [7:0] exp_reads[$];
    logic [7:0] next_miso_byte = 8'h00;
    int         model_wr = 0;
    int         model_rd = 0;

    // Monitor and slave model, sampling mid-cycle on the falling edge.
    always @(negedge clk) begin : mon
        static int         acc_cyc = 0;
        static int         rd_acc = 0;
        static bit         rd_active = 1'b0;
        static logic [7:0] rd_byte = 8'h00;
        static bit         cap_on = 1'b0;
        static int         cap_idx = 0;
        static int         low_cnt = 0;
        static logic [9:0] cap = '0;
        static logic       ss_prev = 1'b1;
        frame_t            e;
        int                d;
        if (rst) begin
            exp_frames.delete();
            exp_reads.delete();
            rd_active = 1'b0;
            cap_on    = 1'b0;
            ss_prev   = 1'b1;
            model_wr  = 0;
            model_rd  = 0;
            miso      = 1'($urandom_range(0, 1));
        end else begin
            d = cyc - rd_acc - CMD_W - TA - 1;
            if (rd_active && d >= 0 && d < DATA_W) miso = rd_byte[DATA_W-1-d];
            else                                    miso = 1'($urandom_range(0, 1));

            if (!ss_n) begin
                if (ss_prev) begin
                    cap_on = 1'b1; cap_idx = 0; low_cnt = 0;
                    check("ss_fall_latency", cyc - acc_cyc, 1);
                end
                low_cnt++;
                check("busy_in_frame", busy, 1);
                if (cap_on && cap_idx < CMD_W) begin
                    cap[CMD_W-1-cap_idx] = mosi;
                    cap_idx++;
                end else begin
                    check("mosi_after_cmd", mosi, 0);
                end
            end else begin
                check("mosi_idle", mosi, 0);
                if (!ss_prev && cap_on) begin
                    cap_on = 1'b0;
                    if (exp_frames.size() == 0) begin
                        check("frame_unexpected", 1, 0);
                    end else begin
                        e = exp_frames.pop_front();
                        check("frame_bits", cap, e.frame);
                        check("ss_low_len", low_cnt, e.low_len);
                    end
                end
            end
            ss_prev = ss_n;

            if (rd_valid) begin
                rd_active = 1'b0;
                if (exp_reads.size() == 0) begin
                    check("rd_valid_unexpected", 1, 0);
                end else begin
                    check("rd_data", rd_data, exp_reads.pop_front());
                    check("rd_latency", cyc - rd_acc, CMD_W + TA + DATA_W + 1);
                end
            end

            if (cmd_valid && cmd_ready) begin
                acc_cyc = cyc;
                if (cmd_op == RD_DATA) begin
                    exp_frames.push_back('{frame: {cmd_op, cmd_data}, low_len: CMD_W + TA + DATA_W});
                    exp_reads.push_back(next_miso_byte);
                    rd_byte = next_miso_byte; rd_acc = cyc; rd_active = 1'b1;
                    model_rd++;
                end else begin
                    exp_frames.push_back('{frame: {cmd_op, cmd_data}, low_len: CMD_W});
                    model_wr++;
                end
            end
        end
    end

    task automatic send(input logic [1:0] op, input logic [7:0] d, input logic [7:0] mb,
                        input bit hold, output int acc);
        bit ok = 1'b0;
        cmd_op = op; cmd_data = d; next_miso_byte = mb; cmd_valid = 1'b1;
        acc = -1;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk);
            if (cmd_ready && !rst) begin ok = 1'b1; acc = cyc; end
        end
        if (!ok) check("accept_timeout", 0, 1);
        @(posedge clk); #1;
        if (!hold) cmd_valid = 1'b0;
    endtask

    task automatic wait_idle();
        bit ok = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            if (cmd_ready && exp_frames.size() == 0 && exp_reads.size() == 0) ok = 1'b1;
        end
        if (!ok) check("idle_timeout", 0, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog cyc=%0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int         a0, a1;
        bit         ok;
        logic [7:0] b_byte;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ss_n", ss_n, 1);
        check("rst_mosi", mosi, 0);
        check("rst_cmd_ready", cmd_ready, 0);
        check("rst_rd_valid", rd_valid, 0);
        check("rst_rd_data", rd_data, 8'h00);
        check("rst_busy", busy, 0);
        @(posedge clk); #1 rst = 1'b0;

        // Single write: cmd_ready comes back 12 cycles after accept.
        send(WR_ADDR, 8'hA5, 8'h00, 1'b0, a0);
        ok = 1'b0;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            if (cmd_ready) ok = 1'b1;
        end
        check("ready_return", ok ? cyc - a0 : -1, CMD_W + GAP + 1);

        send(RD_DATA, 8'h77, 8'h3C, 1'b0, a0);
        wait_idle();

        // cmd_valid held high with changing ops across frames.
        send(WR_ADDR, 8'h11, 8'h00, 1'b1, a0);
        send(WR_DATA, 8'h22, 8'h00, 1'b1, a1);
        check("spacing_wr_1", a1 - a0, CMD_W + GAP + 1);
        send(RD_ADDR, 8'h33, 8'h00, 1'b1, a0);
        check("spacing_wr_2", a0 - a1, CMD_W + GAP + 1);
        send(RD_DATA, 8'h44, 8'hC3, 1'b1, a1);
        check("spacing_wr_3", a1 - a0, CMD_W + GAP + 1);
        send(WR_DATA, 8'h55, 8'h00, 1'b0, a0);
        check("spacing_rd", a0 - a1, CMD_W + TA + DATA_W + GAP + 1);
        wait_idle();

        // Reset in the middle of a read frame.
        send(RD_DATA, 8'h0F, 8'hE7, 1'b0, a0);
        repeat (4) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("midrst_ss_n", ss_n, 1);
        check("midrst_mosi", mosi, 0);
        check("midrst_busy", busy, 0);
        check("midrst_rd_valid", rd_valid, 0);
        @(posedge clk); #1 rst = 1'b0;
        repeat (30) @(negedge clk);

        send(WR_DATA, 8'h3C, 8'h00, 1'b0, a0);
        send(RD_ADDR, 8'h5A, 8'h00, 1'b0, a0);
        send(RD_DATA, 8'h01, 8'h96, 1'b0, a0);
        send(WR_ADDR, 8'hF0, 8'h00, 1'b0, a0);
        send(RD_DATA, 8'h02, 8'h81, 1'b0, a0);
        wait_idle();
        check("frames_left", exp_frames.size(), 0);
        check("reads_left", exp_reads.size(), 0);
`ifdef SPI_MASTER_STATS_EN
        check("stat_wr_cnt", stat_wr_cnt, model_wr);
        check("stat_rd_cnt", stat_rd_cnt, model_rd);
`endif

        // Zero turnaround, three-cycle gap instance.
        b_byte = 8'hC6;
        cmd_op_b = RD_DATA; cmd_data_b = 8'h9D; cmd_valid_b = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            if (cmd_ready_b) ok = 1'b1;
        end
        if (!ok) check("b_accept_timeout", 0, 1);
        @(posedge clk); #1 cmd_valid_b = 1'b0;
        for (int k = 1; k <= CMD_W + TB_TA + DATA_W + TB_GAP + 1; k++) begin
            @(negedge clk);
            if (k > CMD_W + TB_TA && k <= CMD_W + TB_TA + DATA_W)
                miso_b = b_byte[CMD_W + TB_TA + DATA_W - k];
            else
                miso_b = 1'($urandom_range(0, 1));
            check("b_ss_n", ss_n_b, (k <= CMD_W + TB_TA + DATA_W) ? 0 : 1);
            check("b_rd_valid", rd_valid_b, (k == CMD_W + TB_TA + DATA_W + 1) ? 1 : 0);
            check("b_cmd_ready", cmd_ready_b, (k == CMD_W + TB_TA + DATA_W + TB_GAP + 1) ? 1 : 0);
            if (k == CMD_W + TB_TA + DATA_W + 1) check("b_rd_data", rd_data_b, b_byte);
            if (k > CMD_W) check("b_mosi", mosi_b, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
